// File: rtl/idu_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : idu_encoder
//  Description : Packs a decoded RV32 instruction tuple back into a 32-bit
//                instruction word. Encoded words leave through a 2-entry
//                FIFO; tuples that cannot be encoded are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module idu_encoder #(
  parameter int ISA_WIDTH      = 32,
  parameter int INST_NUM_WIDTH = 8,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int IMM_WIDTH      = 32,
  parameter int SHAMT_WIDTH    = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_NUM_WIDTH-1:0] inst_num,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [IMM_WIDTH-1:0]      imm,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ISA_WIDTH-1:0]      inst,
  output logic                      illegal,
  output logic [CNT_WIDTH-1:0]      emit_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt
);

  // Instruction-number codes
  localparam logic [INST_NUM_WIDTH-1:0] OP_ADD    = INST_NUM_WIDTH'(0);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SLL    = INST_NUM_WIDTH'(1);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SLT    = INST_NUM_WIDTH'(2);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SLTU   = INST_NUM_WIDTH'(3);
  localparam logic [INST_NUM_WIDTH-1:0] OP_XOR    = INST_NUM_WIDTH'(4);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SRL    = INST_NUM_WIDTH'(5);
  localparam logic [INST_NUM_WIDTH-1:0] OP_OR     = INST_NUM_WIDTH'(6);
  localparam logic [INST_NUM_WIDTH-1:0] OP_AND    = INST_NUM_WIDTH'(7);
  localparam logic [INST_NUM_WIDTH-1:0] OP_ADDI   = INST_NUM_WIDTH'(8);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SLLI   = INST_NUM_WIDTH'(9);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SRLI   = INST_NUM_WIDTH'(10);
  localparam logic [INST_NUM_WIDTH-1:0] OP_LB     = INST_NUM_WIDTH'(11);
  localparam logic [INST_NUM_WIDTH-1:0] OP_SB     = INST_NUM_WIDTH'(12);
  localparam logic [INST_NUM_WIDTH-1:0] OP_BEQ    = INST_NUM_WIDTH'(13);
  localparam logic [INST_NUM_WIDTH-1:0] OP_EBREAK = INST_NUM_WIDTH'(14);

  // RV32 major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  logic [31:0]          enc_word;
  logic                 enc_bad;
  logic                 imm_fits12;
  logic                 imm_fits13;
  logic [ISA_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // A sign-extended immediate fits N bits when all bits above N-1 copy the sign
  assign imm_fits12 = (&imm[IMM_WIDTH-1:11]) || !(|imm[IMM_WIDTH-1:11]);
  assign imm_fits13 = (&imm[IMM_WIDTH-1:12]) || !(|imm[IMM_WIDTH-1:12]);

  // Combinational encode of the presented tuple plus its legality flag
  always_comb begin
    enc_word = '0;
    enc_bad  = 1'b0;
    case (inst_num)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND:
        // funct3 equals the low three bits of the code for all R-type ops
        enc_word = {7'b0000000, rs2, rs1, inst_num[2:0], rd, OPC_OP};
      OP_ADDI: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_OP_IMM};
        enc_bad  = !imm_fits12;
      end
      OP_SLLI:
        enc_word = {7'b0000000, shamt, rs1, 3'b001, rd, OPC_OP_IMM};
      OP_SRLI:
        enc_word = {7'b0000000, shamt, rs1, 3'b101, rd, OPC_OP_IMM};
      OP_LB: begin
        enc_word = {imm[11:0], rs1, 3'b000, rd, OPC_LOAD};
        enc_bad  = !imm_fits12;
      end
      OP_SB: begin
        enc_word = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OPC_STORE};
        enc_bad  = !imm_fits12;
      end
      OP_BEQ: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
        enc_bad  = !imm_fits13 || imm[0];
      end
      OP_EBREAK:
        enc_word = EBREAK_WORD;
      default:
        enc_bad = 1'b1;
    endcase
  end

  // Handshakes: a full FIFO still accepts when its head leaves on the same edge
  assign out_valid = (count != 2'd0);
  assign inst      = mem[rd_ptr];
  assign in_ready  = (count != 2'd2) || (out_valid && out_ready);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !enc_bad;
  assign pop       = out_valid && out_ready;

  // Two-entry circular FIFO holding encoded words
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ISA_WIDTH'(enc_word);
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Drop pulse and free-running (wrapping) emit/error counters
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal  <= 1'b0;
      emit_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      illegal <= accept && enc_bad;
      if (pop) begin
        emit_cnt <= emit_cnt + CNT_WIDTH'(1);
      end
      if (accept && enc_bad) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire
